// File: rtl/fixed_matmul_sched_pkg.sv
// Shared types for the tiled matmul scheduler.
// Holds the FSM state encoding and the (row, col) output-tile tag.
package fixed_matmul_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int TAG_IDX_WIDTH = 8;

  typedef struct packed {
    logic [TAG_IDX_WIDTH-1:0] row;
    logic [TAG_IDX_WIDTH-1:0] col;
  } tag_t;

endpackage

// File: rtl/fixed_matmul_tag_fifo.sv
// Small FIFO of output-tile tags, oldest tag shown on head.
// Ports: push/push_data, pop, head, full, empty; async active-high rst.
module fixed_matmul_tag_fifo
  import fixed_matmul_sched_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = $bits(tag_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // When full, push+pop writes the slot
      // being popped on the same edge.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/fixed_matmul_tile_scheduler.sv
// Tile scheduler: row->col->k fetch beats, credit throttle, wb tags.
// Ports: cmd_*, req_*, mon_out_*, wb_*, busy, done, err_unexpected.
module fixed_matmul_tile_scheduler
  import fixed_matmul_sched_pkg::*;
#(
  parameter int IDX_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_WIDTH-1:0] cmd_rows,
  input  logic [IDX_WIDTH-1:0] cmd_cols,
  input  logic [IDX_WIDTH-1:0] cmd_depth,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [IDX_WIDTH-1:0] req_row,
  output logic [IDX_WIDTH-1:0] req_col,
  output logic [IDX_WIDTH-1:0] req_k,
  output logic                 req_last,
  output logic                 req_valid,
  input  logic                 req_ready,
  input  logic                 mon_out_valid,
  input  logic                 mon_out_ready,
  output logic [IDX_WIDTH-1:0] wb_row,
  output logic [IDX_WIDTH-1:0] wb_col,
  output logic                 wb_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err_unexpected
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(MAX_OUTSTANDING);

  state_t state_q, state_d;

  logic [IDX_WIDTH-1:0] rows_q, cols_q, depth_q;
  logic [IDX_WIDTH-1:0] row_q, col_q, k_q;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic                 err_q;

  logic cmd_fire, cfg_zero, req_fire, take;
  logic rel_hs, rel, spurious;
  logic k_last, col_last, row_last;
  logic tag_full, tag_empty;
  logic [2*IDX_WIDTH-1:0] tag_head;

  assign cmd_fire = cmd_valid && (state_q == S_IDLE);
  assign cfg_zero = (cmd_rows == '0) || (cmd_cols == '0)
                 || (cmd_depth == '0);

  assign k_last   = (k_q == depth_q - 1'b1);
  assign col_last = (col_q == cols_q - 1'b1);
  assign row_last = (row_q == rows_q - 1'b1);

  assign req_fire = req_valid && req_ready;
  assign take     = req_fire && (k_q == '0);
  assign rel_hs   = mon_out_valid && mon_out_ready;
  assign rel      = rel_hs && (out_cnt != '0);
  assign spurious = rel_hs && (out_cnt == '0);

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        // An empty job drains trivially, giving
        // the same one-cycle gap before done.
        if (cmd_valid) begin
          state_d = cfg_zero ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Only the first beat of a tile needs a credit.
        req_valid = (k_q != '0) || (out_cnt < CNT_MAX);
        if (req_valid && req_ready && k_last
            && col_last && row_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q  <= '0;
      cols_q  <= '0;
      depth_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else if (cmd_fire) begin
      rows_q  <= cmd_rows;
      cols_q  <= cmd_cols;
      depth_q <= cmd_depth;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else if (req_fire) begin
      if (k_last) begin
        k_q <= '0;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      case ({take, rel})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (cmd_fire) begin
        err_q <= spurious;
      end else if (spurious) begin
        err_q <= 1'b1;
      end
    end
  end

  fixed_matmul_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (2 * IDX_WIDTH)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .push      (take),
    .push_data ({row_q, col_q}),
    .pop       (rel),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // The tag FIFO occupancy must track the credit count.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      assert (tag_full == (out_cnt == CNT_MAX)
              && tag_empty == (out_cnt == '0));
    end
  end

  assign req_row        = row_q;
  assign req_col        = col_q;
  assign req_k          = k_q;
  assign req_last       = k_last;
  assign wb_row         = tag_head[2*IDX_WIDTH-1:IDX_WIDTH];
  assign wb_col         = tag_head[IDX_WIDTH-1:0];
  assign wb_valid       = (out_cnt != '0);
  assign err_unexpected = err_q;

endmodule
